// File: rtl/jt10_rom_pkg.sv
// Shared types and widths for the JT10 ADPCM ROM bridge.
//   state_e : arbiter/fetch FSM states
//   ADDR_W  : shared memory byte address width
//   DATA_W  : memory data width
package jt10_rom_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_A = 2'd1,
    FETCH_B = 2'd2
  } state_e;

endpackage

// File: rtl/jt10_rom_chreq.sv
// Per-channel request tracker for the ADPCM ROM bridge.
// Detects ROM output-enable falls and address changes, holds the pending
// flag and the requested address, and maintains the "data matches address"
// flag. With JT10_ROM_CACHE_EN defined it also keeps a one-entry tag of the
// last fetched address so a repeat request is satisfied without memory.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   roe_n      : channel ROM output enable (active low)
//   addr       : channel address already mapped into shared memory space
//   grant      : pulse, the bridge has started a fetch for req_addr
//   done       : pulse, the in-flight fetch for this channel was acked
//   pend_c     : pending request that needs a memory access (combinational)
//   req_addr   : address of the pending request
//   ok         : channel data output matches the current address
module jt10_rom_chreq
  import jt10_rom_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              roe_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              grant,
  input  logic              done,
  output logic              pend_c,
  output logic [ADDR_W-1:0] req_addr,
  output logic              ok
);

  logic              roe_n_q, roe_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              ok_q, ok_d;
  logic              trig_c;
  logic              hit_c;

`ifdef JT10_ROM_CACHE_EN
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] fly_q, fly_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic              tag_v_q, tag_v_d;

  // A hit is only trusted when no fetch of this channel is in flight,
  // since that fetch would overwrite the channel data afterwards.
  assign hit_c = pend_q && tag_v_q && !busy_q && (req_addr_q == tag_q);

  // Tag tracks the address whose byte currently sits in the data output.
  always_comb begin
    busy_d  = busy_q;
    fly_d   = fly_q;
    tag_d   = tag_q;
    tag_v_d = tag_v_q;
    if (grant) begin
      busy_d = 1'b1;
      fly_d  = req_addr_q;
    end
    if (done) begin
      busy_d  = 1'b0;
      tag_d   = fly_q;
      tag_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      fly_q   <= '0;
      tag_q   <= '0;
      tag_v_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      fly_q   <= fly_d;
      tag_q   <= tag_d;
      tag_v_q <= tag_v_d;
    end
  end
`else
  assign hit_c = 1'b0;
`endif

  // New request: enable just fell, or address moved while enabled.
  assign trig_c = !roe_n && (roe_n_q || (addr != addr_q));

  // A fresh trigger beats a same-cycle grant so a change during the grant
  // cycle is refetched rather than lost.
  always_comb begin
    roe_n_d    = roe_n;
    addr_d     = addr;
    pend_d     = pend_q;
    req_addr_d = req_addr_q;
    ok_d       = ok_q;
    if (trig_c) begin
      pend_d     = 1'b1;
      req_addr_d = addr;
      ok_d       = 1'b0;
    end else begin
      if (grant || hit_c) pend_d = 1'b0;
      if (hit_c) ok_d = 1'b1;
      else if (done && !pend_q) ok_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      roe_n_q    <= 1'b1;
      addr_q     <= '0;
      pend_q     <= 1'b0;
      req_addr_q <= '0;
      ok_q       <= 1'b0;
    end else begin
      roe_n_q    <= roe_n_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      req_addr_q <= req_addr_d;
      ok_q       <= ok_d;
    end
  end

  assign pend_c   = pend_q && !hit_c;
  assign req_addr = req_addr_q;
  assign ok       = ok_q;

endmodule

// File: rtl/jt10_adpcm_rom_bridge.sv
// Bridges the YM2610 ADPCM-A and ADPCM-B ROM ports onto one shared byte
// memory with a level request / one-cycle acknowledge handshake.
// Optional one-entry per-channel cache: define JT10_ROM_CACHE_EN.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   adpcma_addr/bank/roe_n    : ADPCM-A ROM address, bank, output enable
//   adpcma_data, adpcma_ok    : ADPCM-A fetched byte and its validity
//   adpcmb_addr/roe_n         : ADPCM-B ROM address, output enable
//   adpcmb_data, adpcmb_ok    : ADPCM-B fetched byte and its validity
//   mem_addr, mem_req         : shared memory byte address and request level
//   mem_ack, mem_data         : one-cycle acknowledge with read data
module jt10_adpcm_rom_bridge
  import jt10_rom_pkg::*;
#(
  parameter logic [24:0] A_OFFSET = 25'h0,
  parameter logic [24:0] B_OFFSET = 25'h100_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] adpcma_addr,
  input  logic [3:0]  adpcma_bank,
  input  logic        adpcma_roe_n,
  output logic [7:0]  adpcma_data,
  input  logic [23:0] adpcmb_addr,
  input  logic        adpcmb_roe_n,
  output logic [7:0]  adpcmb_data,
  output logic        adpcma_ok,
  output logic        adpcmb_ok,
  output logic [24:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              rr_b_q, rr_b_d;

  logic [ADDR_W-1:0] a_addr_c, b_addr_c;
  logic [ADDR_W-1:0] a_req_addr, b_req_addr;
  logic              a_pend_c, b_pend_c;
  logic              a_grant_c, b_grant_c;
  logic              a_done_c, b_done_c;

  // Map channel addresses into the shared space; sums wrap at 25 bits.
  assign a_addr_c = ADDR_W'({1'b0, adpcma_bank, adpcma_addr}) + A_OFFSET;
  assign b_addr_c = ADDR_W'({1'b0, adpcmb_addr}) + B_OFFSET;

  jt10_rom_chreq u_cha (
    .clk      (clk),
    .rst      (rst),
    .roe_n    (adpcma_roe_n),
    .addr     (a_addr_c),
    .grant    (a_grant_c),
    .done     (a_done_c),
    .pend_c   (a_pend_c),
    .req_addr (a_req_addr),
    .ok       (adpcma_ok)
  );

  jt10_rom_chreq u_chb (
    .clk      (clk),
    .rst      (rst),
    .roe_n    (adpcmb_roe_n),
    .addr     (b_addr_c),
    .grant    (b_grant_c),
    .done     (b_done_c),
    .pend_c   (b_pend_c),
    .req_addr (b_req_addr),
    .ok       (adpcmb_ok)
  );

  // Arbitration and fetch sequencing. The round-robin pointer only moves on
  // contested grants: the loser of a tie wins the next tie.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    a_data_d   = a_data_q;
    b_data_d   = b_data_q;
    rr_b_d     = rr_b_q;
    a_grant_c  = 1'b0;
    b_grant_c  = 1'b0;
    a_done_c   = 1'b0;
    b_done_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_pend_c && (!b_pend_c || !rr_b_q)) begin
          a_grant_c  = 1'b1;
          state_d    = FETCH_A;
          mem_req_d  = 1'b1;
          mem_addr_d = a_req_addr;
          if (b_pend_c) rr_b_d = 1'b1;
        end else if (b_pend_c) begin
          b_grant_c  = 1'b1;
          state_d    = FETCH_B;
          mem_req_d  = 1'b1;
          mem_addr_d = b_req_addr;
          if (a_pend_c) rr_b_d = 1'b0;
        end
      end
      FETCH_A: begin
        if (mem_ack) begin
          a_done_c  = 1'b1;
          a_data_d  = mem_data;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      FETCH_B: begin
        if (mem_ack) begin
          b_done_c  = 1'b1;
          b_data_d  = mem_data;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      a_data_q   <= '0;
      b_data_q   <= '0;
      rr_b_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      a_data_q   <= a_data_d;
      b_data_q   <= b_data_d;
      rr_b_q     <= rr_b_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign adpcma_data = a_data_q;
  assign adpcmb_data = b_data_q;

endmodule
